// File: rtl/stbus_pkg.sv
// stbus_pkg: shared constants and types for the ST-bus receive deframer.
// Optional sync-error counter is enabled with STBUS_RX_SYNC_CNT_EN.
package stbus_pkg;

  localparam int CHANNELS       = 32;
  localparam int BITS_PER_FRAME = 256;
  localparam int C4_PER_FRAME   = 512;

  typedef enum logic {
    HUNT,
    SYNC
  } stbus_rx_state_t;

  typedef logic [7:0] chan_byte_t;
  typedef logic [8:0] cnt_t;

endpackage

// File: rtl/stbus_sync.sv
// stbus_sync: 2-FF synchroniser for c4/f0/data plus c4 rising-edge detect.
// All three inputs share one pipeline so they stay mutually aligned.
module stbus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic c4,
  input  logic f0,
  input  logic data,
  output logic c4_s,
  output logic f0_s,
  output logic data_s,
  output logic c4_rise
);

  logic [2:0] meta;
  logic       c4_d;

  // f0 idles high, so it resets to its inactive level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 3'b010;
      c4_s   <= 1'b0;
      f0_s   <= 1'b1;
      data_s <= 1'b0;
      c4_d   <= 1'b0;
    end else begin
      meta   <= {c4, f0, data};
      c4_s   <= meta[2];
      f0_s   <= meta[1];
      data_s <= meta[0];
      c4_d   <= c4_s;
    end
  end

  assign c4_rise = c4_s & ~c4_d;

endmodule

// File: rtl/stbus_rx_deframer.sv
// stbus_rx_deframer: ST-bus frame capture into a ping-pong channel buffer.
// Define STBUS_RX_SYNC_CNT_EN to add the sync_err_cnt output.
module stbus_rx_deframer #(
  parameter int unsigned CHANNELS       = 32,
  parameter int unsigned FRAMES_PER_IRQ = 12
) (
  input  logic       clk50,
  input  logic       reset_n,
  input  logic       c4,
  input  logic       f0,
  input  logic       data_from_dt,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  input  logic       int_ack,
  output logic       frame_done,
  output logic       bank_sel,
  output logic       cpu_int,
  output logic       sync_err
`ifdef STBUS_RX_SYNC_CNT_EN
  ,
  output logic [7:0] sync_err_cnt
`endif
);

  import stbus_pkg::*;

  localparam cnt_t LAST = cnt_t'(C4_PER_FRAME - 1);
  localparam logic [7:0] FPI_LAST = 8'(FRAMES_PER_IRQ - 1);

  logic c4_s, f0_s, data_s, c4_rise;

  stbus_sync u_sync (
    .clk    (clk50),
    .rst_n  (reset_n),
    .c4     (c4),
    .f0     (f0),
    .data   (data_from_dt),
    .c4_s   (c4_s),
    .f0_s   (f0_s),
    .data_s (data_s),
    .c4_rise(c4_rise)
  );

  stbus_rx_state_t state, state_nx;
  cnt_t       cnt, cnt_nx, inc;
  logic [6:0] shreg, shreg_nx;
  logic       wr_en, swap_nx, err_nx;
  logic [4:0] wr_ch;
  logic       wr_bank, swap, rd_bank;
  logic [7:0] fcnt;
  logic       int_set;
  chan_byte_t mem [2][CHANNELS];

  assign inc = cnt + 9'd1;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    shreg_nx = shreg;
    wr_en    = 1'b0;
    wr_ch    = inc[8:4];
    swap_nx  = 1'b0;
    err_nx   = 1'b0;
    if (c4_rise) begin
      unique case (state)
        HUNT: begin
          if (!f0_s) begin
            cnt_nx   = '0;
            state_nx = SYNC;
          end
        end
        SYNC: begin
          unique case (1'b1)
            !f0_s: begin
              cnt_nx = '0;
              err_nx = (cnt != LAST);
            end
            f0_s && (cnt == LAST): begin
              err_nx   = 1'b1;
              state_nx = HUNT;
            end
            default: begin
              cnt_nx = inc;
              // odd count carries bit (inc>>1); byte closes on bit 7
              if (inc[0]) begin
                shreg_nx = {shreg[5:0], data_s};
                wr_en    = (inc[3:1] == 3'b111);
                swap_nx  = (inc == LAST);
              end
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign int_set = swap && (fcnt == FPI_LAST);
  assign rd_bank = swap ? wr_bank : ~wr_bank;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      cnt        <= '0;
      shreg      <= '0;
      swap       <= 1'b0;
      wr_bank    <= 1'b0;
      bank_sel   <= 1'b0;
      frame_done <= 1'b0;
      fcnt       <= '0;
      cpu_int    <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      shreg      <= shreg_nx;
      swap       <= swap_nx;
      frame_done <= swap;
      if (swap) begin
        wr_bank  <= ~wr_bank;
        bank_sel <= wr_bank;
        fcnt     <= (fcnt == FPI_LAST) ? 8'd0 : fcnt + 8'd1;
      end
      cpu_int  <= int_set | (cpu_int & ~int_ack);
      sync_err <= err_nx | (sync_err & ~int_ack);
    end
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= '0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < int'(CHANNELS); c++)
          mem[b][c] <= '0;
    end else begin
      rd_data <= mem[rd_bank][rd_addr];
      if (wr_en)
        mem[wr_bank][wr_ch] <= {shreg, data_s};
    end
  end

`ifdef STBUS_RX_SYNC_CNT_EN
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync_err_cnt <= '0;
    end else begin
      unique case (1'b1)
        err_nx && int_ack:
          sync_err_cnt <= 8'd1;
        err_nx && !int_ack:
          if (sync_err_cnt != 8'hFF)
            sync_err_cnt <= sync_err_cnt + 8'd1;
        !err_nx && int_ack:
          sync_err_cnt <= '0;
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_stbus_rx_deframer.sv
// tb_stbus_rx_deframer: random-frame bench with a frame-level reference model.
// Define STBUS_RX_SYNC_CNT_EN to also exercise sync_err_cnt.
module tb_stbus_rx_deframer;

  localparam int FPI = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       c4, f0, data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic       int_ack;
  logic       frame_done, bank_sel, cpu_int, sync_err;
`ifdef STBUS_RX_SYNC_CNT_EN
  logic [7:0] sync_err_cnt;
`endif

  stbus_rx_deframer #(
    .CHANNELS      (32),
    .FRAMES_PER_IRQ(FPI)
  ) dut (
    .clk50       (clk),
    .reset_n     (reset_n),
    .c4          (c4),
    .f0          (f0),
    .data_from_dt(data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .int_ack     (int_ack),
    .frame_done  (frame_done),
    .bank_sel    (bank_sel),
    .cpu_int     (cpu_int),
    .sync_err    (sync_err)
`ifdef STBUS_RX_SYNC_CNT_EN
    ,
    .sync_err_cnt(sync_err_cnt)
`endif
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // frame-level model state
  int   n_frames   = 0;
  int   exp_frames = 0;
  int   since_rst  = 0;
  int   m_fcnt     = 0;
  logic m_int      = 1'b0;
  logic [7:0] exp_bank [32];
  logic [7:0] fr [32];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && frame_done) begin
      n_frames++;
      since_rst++;
      m_fcnt++;
      if (m_fcnt == FPI) begin
        m_fcnt = 0;
        m_int  = 1'b1;
      end
      check("int_at_done", 32'(cpu_int), 32'(m_int));
      check("bank_sel", 32'(bank_sel), 32'((since_rst - 1) & 1));
    end
  end

  task automatic rise(input logic f0v, input logic dv);
    c4 = 1'b0;
    f0 = f0v;
    data = dv;
    repeat (5) @(negedge clk);
    c4 = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  // rises 1..upto of a frame; bit k>>1 is held so odd rises see it
  task automatic body(input logic [7:0] b [32], input int upto);
    for (int k = 1; k <= upto; k++) begin
      int bi;
      bi = k >> 1;
      rise(1'b1, b[bi >> 3][7 - (bi & 7)]);
    end
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 32; i++)
      fr[i] = 8'($urandom);
  endtask

  task automatic full_frame(input logic [7:0] b [32]);
    rise(1'b0, 1'b0);
    body(b, 511);
    exp_frames++;
    exp_bank = b;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      rd_addr = 5'(a);
      @(negedge clk);
      check(tag, 32'(rd_data), 32'(exp_bank[a]));
    end
  endtask

  task automatic ack();
    @(negedge clk);
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    m_int = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    c4 = 1'b0;
    f0 = 1'b1;
    data = 1'b0;
    rd_addr = '0;
    int_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_bank_sel", 32'(bank_sel), 0);
    check("rst_cpu_int", 32'(cpu_int), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_rd_data", 32'(rd_data), 0);
`ifdef STBUS_RX_SYNC_CNT_EN
    check("rst_err_cnt", 32'(sync_err_cnt), 0);
`endif
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // frame A: channel n carries n*7
    for (int i = 0; i < 32; i++)
      fr[i] = 8'(i * 7);
    full_frame(fr);
    check("a_frames", 32'(n_frames), 32'(exp_frames));
    check("a_bank_sel", 32'(bank_sel), 0);
    check("a_cpu_int", 32'(cpu_int), 0);
    @(negedge clk);
    rd_addr = 5'd5;
    @(negedge clk);
    check("a_addr5", 32'(rd_data), 32'h23);
    rd_addr = 5'd31;
    @(negedge clk);
    check("a_addr31", 32'(rd_data), 32'hD9);
    read_all("a_data");

    // frame B completes the interrupt period
    rand_frame();
    full_frame(fr);
    check("b_frames", 32'(n_frames), 32'(exp_frames));
    check("b_cpu_int", 32'(cpu_int), 32'(m_int));
    read_all("b_data");
    ack();
    check("ack_cpu_int", 32'(cpu_int), 0);

    rand_frame();
    full_frame(fr);
    check("c_cpu_int", 32'(cpu_int), 32'(m_int));
    rand_frame();
    full_frame(fr);
    check("d_frames", 32'(n_frames), 32'(exp_frames));
    check("d_cpu_int", 32'(cpu_int), 32'(m_int));
    read_all("d_data");

    // early f0 at cnt=200
    rand_frame();
    rise(1'b0, 1'b0);
    body(fr, 200);
    rise(1'b0, 1'b0);
    check("early_sync_err", 32'(sync_err), 1);
    check("early_no_done", 32'(n_frames), 32'(exp_frames));
    rand_frame();
    body(fr, 511);
    exp_frames++;
    exp_bank = fr;
    check("e_frames", 32'(n_frames), 32'(exp_frames));
    read_all("e_data");

    // f0 missing after the last rise: lose lock
    ack();
    check("ack_sync_err", 32'(sync_err), 0);
    for (int i = 0; i < 5; i++)
      rise(1'b1, 1'(i));
    check("lost_sync_err", 32'(sync_err), 1);
    check("lost_no_done", 32'(n_frames), 32'(exp_frames));
    ack();
    rand_frame();
    full_frame(fr);
    check("f_frames", 32'(n_frames), 32'(exp_frames));
    check("f_sync_err", 32'(sync_err), 0);
    check("f_cpu_int", 32'(cpu_int), 32'(m_int));
    read_all("f_data");

    // reset mid-frame at cnt=300
    rand_frame();
    rise(1'b0, 1'b0);
    body(fr, 300);
    reset_n = 1'b0;
    #1;
    check("mid_frame_done", 32'(frame_done), 0);
    check("mid_bank_sel", 32'(bank_sel), 0);
    check("mid_cpu_int", 32'(cpu_int), 0);
    check("mid_sync_err", 32'(sync_err), 0);
    check("mid_rd_data", 32'(rd_data), 0);
    since_rst = 0;
    m_fcnt = 0;
    m_int = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++)
      exp_bank[i] = 8'h00;
    for (int i = 0; i < 20; i++)
      rise(1'b1, 1'b1);
    check("hunt_no_done", 32'(n_frames), 32'(exp_frames));
    read_all("clr_data");
    rand_frame();
    full_frame(fr);
    check("g_frames", 32'(n_frames), 32'(exp_frames));
    check("g_bank_sel", 32'(bank_sel), 0);
    check("g_sync_err", 32'(sync_err), 0);
    read_all("g_data");

`ifdef STBUS_RX_SYNC_CNT_EN
    // 1 normal re-lock followed by 260 early f0 pulses
    rise(1'b0, 1'b0);
    for (int i = 0; i < 260; i++)
      rise(1'b0, 1'b0);
    check("cnt_sat", 32'(sync_err_cnt), (260 > 255) ? 255 : 260);
    check("cnt_sync_err", 32'(sync_err), 1);
    ack();
    check("cnt_ack", 32'(sync_err_cnt), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/stbus_rx_deframer.md
# stbus_rx_deframer

Receive-side ST-bus deframer for the line card. Runs on `clk50` and oversamples the `c4`/`f0` timing pair and the `data_from_dt` serial stream. It assembles each 256-bit frame into 32 channel bytes in a ping-pong buffer, and raises `cpu_int` once every `FRAMES_PER_IRQ` frames so the CPU can read the completed bank. It sits directly downstream of the `data_from_dt` line and provides the per-frame interrupt timing that the converter stage otherwise generates on its own.

## Interface
- `CHANNELS`, 32: timeslots per frame, 8 bits each, MSB first.
- `FRAMES_PER_IRQ`, 12: completed frames per `cpu_int` assertion; range 1..255.
- `clk50`  in  1  system clock, 50 MHz.
- `reset_n`  in  1  asynchronous active-low reset.
- `c4`  in  1  ST-bus 4.096 MHz clock; asynchronous to `clk50`.
- `f0`  in  1  ST-bus frame pulse, active low; asynchronous.
- `data_from_dt`  in  1  serial receive data; asynchronous.
- `rd_addr`  in  5  channel index into the completed bank.
- `rd_data`  out  8  registered channel byte.
- `int_ack`  in  1  one-cycle pulse; clears `cpu_int` and `sync_err`.
- `frame_done`  out  1  one-cycle pulse on each bank swap.
- `bank_sel`  out  1  bank currently readable by the CPU.
- `cpu_int`  out  1  level interrupt request.
- `sync_err`  out  1  sticky frame-alignment error.

## Operation
- Reset values: every output 0; state HUNT; `cnt`=0; write bank 0; frame counter 0; both buffer banks 0.
- `c4`, `f0` and `data_from_dt` pass through the same 2-FF synchroniser, so they stay mutually aligned. A third FF on `c4` produces `c4_rise`. All decisions below are taken on `c4_rise` cycles only.
- FSM states are HUNT and SYNC.
- **HUNT**
  - On `c4_rise` with `f0`=0: `cnt`←0, go to SYNC.
  - Otherwise hold; no writes occur.
- **SYNC**
  - Each `c4_rise` increments the 9-bit `cnt`.
  - On odd `cnt`, sample data. Bit index b = `cnt`>>1; channel = b[7:3]; bit position = 7−b[2:0].
  - The shift byte is written to `mem[wr_bank][channel]` on the sample where b[2:0]=7.
- **Frame completion**
  - On the sample at `cnt`=511, the write happens as usual.
  - On the next `clk50` cycle: toggle `wr_bank`, set `bank_sel`←old `wr_bank`, pulse `frame_done`, increment the frame counter.
- **Re-alignment on the next `c4_rise` after `cnt`=511**
  - `f0`=0: `cnt`←0 and stay in SYNC.
  - `f0`=1: set `sync_err`, go to HUNT.
- **Early `f0`**
  - `f0`=0 on a `c4_rise` with `cnt`≠511: set `sync_err`, discard the partial frame (no swap), `cnt`←0, stay in SYNC.
- **Interrupt**
  - When the frame counter reaches `FRAMES_PER_IRQ`, it wraps to 0 and `cpu_int`←1.
  - `int_ack` clears `cpu_int` and `sync_err`.
  - If set and `int_ack` occur in the same cycle, set wins.
- **Read port**
  - `rd_data` ← `mem[~wr_bank][rd_addr]`.
  - A read in the swap cycle already returns the newly completed bank.
- **Reset mid-frame:** immediate return to HUNT; buffer contents are cleared.

## Timing
- `rd_data` latency: 1 `clk50` cycle after `rd_addr`.
- Sample to `mem` write: same cycle as the `c4_rise` that carries the sample.
- `f0`/`c4` pin to `c4_rise`: 3 `clk50` cycles.
- Final bit pin to `frame_done`: 4 `clk50` cycles.
- `frame_done` to `cpu_int`: 0 cycles, i.e. both assert in the same cycle on the interrupt frame.
- A frame spans 512 `c4` rises, about 6250 `clk50` cycles. `c4` high and low each last ≥5 `clk50` cycles.

## Configuration
- `STBUS_RX_SYNC_CNT_EN`
  - Defined: adds output port `sync_err_cnt[7:0]`. It counts `sync_err` events, saturates at 255 and is cleared by `int_ack`. An event coincident with `int_ack` makes the count 1.
  - Undefined: the port and counter are absent; only the sticky `sync_err` remains.

## Structure
- Package `stbus_pkg`:
  - constants `CHANNELS`, `BITS_PER_FRAME`=256, `C4_PER_FRAME`=512;
  - enum `stbus_rx_state_t` {HUNT, SYNC};
  - typedef `chan_byte_t` (8-bit).
- Sub-module `stbus_sync`: 3-input, 2-FF synchroniser plus the `c4` rising-edge detector.

## Test plan
- Reset, then ideal `f0`/`c4` with channel n carrying byte n×7 → `frame_done` pulses once; reading addr 5 gives 0x23, addr 31 gives 0xD9; `bank_sel`=0.
- 12 consecutive frames with `FRAMES_PER_IRQ`=12 → `cpu_int` rises with the 12th `frame_done`. `int_ack` clears it; it re-asserts after 12 more frames.
- `f0` asserted at `cnt`=200 → `sync_err`=1; no `frame_done` for the partial frame; the next full frame is captured correctly.
- `f0` held high after `cnt`=511 → `sync_err`=1, state HUNT, no further writes. A later `f0` low re-locks, and the next frame completes.
- `reset_n` low at `cnt`=300 → all outputs 0 immediately, `rd_data` 0 for every address. Capture resumes only after the next `f0`.
- With `STBUS_RX_SYNC_CNT_EN`: 260 early-`f0` events → `sync_err_cnt`=255; `int_ack` → 0.
